// File: rtl/pixel_clock_pkg.sv
// pixel_clock_pkg
// Shared constants and helpers for the pixel-clock generator and the VGA
// timing generator that runs off its strobe.
//   - Default oscillator and pixel frequencies.
//   - Width of the lock strobe counter.
//   - VGA 640x480 horizontal (pixels) and vertical (lines) timing.
//   - calc_inc(): phase increment for the DDS divider.
package pixel_clock_pkg;

  localparam int unsigned DEFAULT_REF_FREQ_HZ = 133_000_000;
  localparam int unsigned DEFAULT_OUT_FREQ_HZ = 25_175_000;

  localparam int unsigned LOCK_CNT_WIDTH = 16;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // round(out_hz * 2^width / ref_hz), round-half-up. The product is formed
  // by binary long division so that widths up to 48 bits never overflow the
  // 64-bit intermediate, which a direct multiply would.
  function automatic logic [63:0] calc_inc(input logic [63:0] ref_hz,
                                           input logic [63:0] out_hz,
                                           input int unsigned width);
    logic [63:0] quo;
    logic [63:0] rem;
    quo = out_hz / ref_hz;
    rem = out_hz % ref_hz;
    for (int unsigned i = 0; i < width; i++) begin
      quo = quo << 1;
      rem = rem << 1;
      if (rem >= ref_hz) begin
        rem = rem - ref_hz;
        quo = quo | 64'd1;
      end
    end
    if ((rem << 1) >= ref_hz) begin
      quo = quo + 64'd1;
    end
    return quo;
  endfunction

endpackage

// File: rtl/pixel_clock_gen_lock_detector.sv
// lock_detector
// Counts pixel strobes after reset or standby and raises lock once the
// programmed number has been seen.
//   clki    in  reference clock
//   rst_n   in  asynchronous active-low reset
//   stdby   in  standby; clears the count and the lock flag
//   pclk_en in  strobe that is being registered on this edge
//   lock    out registered lock flag, sticky until reset or standby
module lock_detector
  import pixel_clock_pkg::*;
#(
  parameter int unsigned LOCK_STROBES = 1024
) (
  input  logic clki,
  input  logic rst_n,
  input  logic stdby,
  input  logic pclk_en,
  output logic lock
);

  localparam logic [LOCK_CNT_WIDTH-1:0] TARGET = LOCK_CNT_WIDTH'(LOCK_STROBES);
  localparam logic [LOCK_CNT_WIDTH-1:0] ONE    = LOCK_CNT_WIDTH'(1);

  logic [LOCK_CNT_WIDTH-1:0] cnt_q;
  logic [LOCK_CNT_WIDTH-1:0] cnt_d;
  logic                      lock_q;
  logic                      lock_d;

  // The counter saturates at all-ones; at saturation cnt_q+1 wraps to zero,
  // which can never match TARGET (>= 1), and lock is sticky anyway.
  always_comb begin
    cnt_d  = cnt_q;
    lock_d = lock_q;
    if (stdby) begin
      cnt_d  = '0;
      lock_d = 1'b0;
    end else if (pclk_en) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + ONE;
      end
      if ((cnt_q + ONE) == TARGET) begin
        lock_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

  assign lock = lock_q;

endmodule

// File: rtl/pixel_clock_gen.sv
// pixel_clock_gen
// DDS pixel-clock divider: a phase accumulator stepped by a constant
// increment each reference cycle; its carry is the pixel strobe and its MSB
// is a ~50% duty pixel clock.
//   clki    in  reference (oscillator) clock
//   rst_n   in  asynchronous active-low reset
//   stdby   in  standby; freezes the accumulator and clears lock
//   pclk    out pixel clock (accumulator MSB)
//   pclk_en out one-cycle strobe per pixel period
//   lock    out high once LOCK_STROBES strobes have been produced
module pixel_clock_gen
  import pixel_clock_pkg::*;
#(
  parameter int unsigned REF_FREQ_HZ  = DEFAULT_REF_FREQ_HZ,
  parameter int unsigned OUT_FREQ_HZ  = DEFAULT_OUT_FREQ_HZ,
  parameter int unsigned ACC_WIDTH    = 32,
  parameter int unsigned LOCK_STROBES = 1024
) (
  input  logic clki,
  input  logic rst_n,
  input  logic stdby,
  output logic pclk,
  output logic pclk_en,
  output logic lock
);

  if (OUT_FREQ_HZ >= REF_FREQ_HZ / 2) begin : g_bad_freq
    $error("pixel_clock_gen: OUT_FREQ_HZ must be below REF_FREQ_HZ/2");
  end
  if (ACC_WIDTH < 16 || ACC_WIDTH > 48) begin : g_bad_width
    $error("pixel_clock_gen: ACC_WIDTH must be within 16..48");
  end
  if (LOCK_STROBES < 1 || LOCK_STROBES > 65535) begin : g_bad_lock
    $error("pixel_clock_gen: LOCK_STROBES must be within 1..65535");
  end

  localparam logic [ACC_WIDTH-1:0] INC =
    ACC_WIDTH'(calc_inc(64'(REF_FREQ_HZ), 64'(OUT_FREQ_HZ), ACC_WIDTH));

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 carry_d;
  logic                 strobe_d;
  logic                 pclk_q;
  logic                 pclk_en_q;

  // strobe_d is the strobe about to be registered; the lock detector sees it
  // on the same edge so lock rises together with the qualifying pclk_en.
  always_comb begin
    {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, INC};
    strobe_d         = carry_d & ~stdby;
  end

  // In standby the accumulator holds, so a carry that would have happened is
  // simply deferred to the first active edge rather than lost.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      pclk_q    <= 1'b0;
      pclk_en_q <= 1'b0;
    end else if (stdby) begin
      pclk_en_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      pclk_q    <= acc_d[ACC_WIDTH-1];
      pclk_en_q <= carry_d;
    end
  end

  lock_detector #(
    .LOCK_STROBES(LOCK_STROBES)
  ) u_lock_detector (
    .clki   (clki),
    .rst_n  (rst_n),
    .stdby  (stdby),
    .pclk_en(strobe_d),
    .lock   (lock)
  );

  assign pclk    = pclk_q;
  assign pclk_en = pclk_en_q;

endmodule

// File: tb/tb_pixel_clock_gen.sv
// tb_pixel_clock_gen
// Scoreboard bench: the driver pushes expected strobes (edge number and lock
// value) into a queue; a monitor on the falling edge pops and compares
// whenever pclk_en is seen, and flags strobes that are missing or extra.
module tb_pixel_clock_gen;

  localparam longint unsigned INC_DEF  = 64'd812975952;
  localparam int              LOCK_DEF = 1024;

  logic clki  = 1'b0;
  logic rst_n = 1'b0;
  logic stdby = 1'b0;

  logic pclk, pclkEn, lock;
  logic pclk4, pclkEn4, lock4;
  logic pclkB, pclkEnB, lockB;

  pixel_clock_gen dut (
    .clki   (clki),
    .rst_n  (rst_n),
    .stdby  (stdby),
    .pclk   (pclk),
    .pclk_en(pclkEn),
    .lock   (lock)
  );

  pixel_clock_gen #(
    .LOCK_STROBES(4)
  ) dut4 (
    .clki   (clki),
    .rst_n  (rst_n),
    .stdby  (stdby),
    .pclk   (pclk4),
    .pclk_en(pclkEn4),
    .lock   (lock4)
  );

  pixel_clock_gen #(
    .REF_FREQ_HZ(100_000_000),
    .OUT_FREQ_HZ(25_000_000)
  ) dutB (
    .clki   (clki),
    .rst_n  (rst_n),
    .stdby  (stdby),
    .pclk   (pclkB),
    .pclk_en(pclkEnB),
    .lock   (lockB)
  );

  always #5 clki = ~clki;

  typedef struct {
    int edgeNo;
    bit lockExp;
  } sbRec_t;

  sbRec_t sbQ[$];

  int checkCount = 0;
  int passCount  = 0;

  int              edgeNo     = 0;
  int              handUntil  = 0;
  longint unsigned activeK    = 0;
  int              strobeCnt  = 0;
  bit              directedOn = 1'b0;
  bit              intervalOn = 1'b0;

  int     monEdge     = 0;
  int     lastStrobe  = 0;
  int     strobeTotal = 0;
  int     monIv;
  sbRec_t monRec;

  // First eight strobe edges for the default increment: ceil(m * 2^32 / INC).
  int handEdges [8] = '{6, 11, 16, 22, 27, 32, 37, 43};

  task automatic checkOutput(input string name, input longint act,
                             input longint exp, input longint tol = 0);
    checkCount++;
    if (act >= exp - tol && act <= exp + tol) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual %0d, required %0d (tolerance %0d) at %0t",
               name, act, exp, tol, $time);
    end
  endtask

  function automatic bit strobeAt(input longint unsigned k);
    return ((k * INC_DEF) >> 32) != (((k - 1) * INC_DEF) >> 32);
  endfunction

  function automatic longint unsigned accModel(input longint unsigned k);
    return (k * INC_DEF) & 64'hFFFF_FFFF;
  endfunction

  always @(posedge clki or negedge rst_n) begin
    if (!rst_n) monEdge <= 0;
    else        monEdge <= monEdge + 1;
  end

  always @(negedge clki or negedge rst_n) begin
    if (!rst_n) begin
      lastStrobe  = 0;
      strobeTotal = 0;
    end else if (pclkEn) begin
      strobeTotal++;
      if (intervalOn && lastStrobe > 0) begin
        monIv = monEdge - lastStrobe;
        checkOutput("strobeInterval", monIv, (monIv <= 5) ? 5 : 6);
      end
      lastStrobe = monEdge;
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedStrobeAtEdge", monEdge, 0);
      end else begin
        monRec = sbQ.pop_front();
        checkOutput("strobeEdge", monEdge, monRec.edgeNo);
        checkOutput("lockAtStrobe", lock, monRec.lockExp);
      end
    end else if (sbQ.size() > 0 && sbQ[0].edgeNo <= monEdge) begin
      monRec = sbQ.pop_front();
      checkOutput("missedStrobeAtEdge", 0, monRec.edgeNo);
    end
  end

  task automatic stepEdge();
    sbRec_t rec;
    @(posedge clki);
    #1;
    edgeNo++;
    if (!stdby) begin
      activeK++;
      if (strobeAt(activeK)) begin
        strobeCnt++;
        if (edgeNo > handUntil) begin
          rec.edgeNo  = edgeNo;
          rec.lockExp = (strobeCnt >= LOCK_DEF);
          sbQ.push_back(rec);
        end
      end
    end else begin
      strobeCnt = 0;
    end
    if (directedOn && edgeNo <= 40) begin
      if (edgeNo == 1) checkOutput("accAfterEdge1", longint'(dut.acc_q), INC_DEF);
      checkOutput("lockStrobes4", lock4, (edgeNo >= 22) ? 1 : 0);
      checkOutput("pclkEnDiv4", pclkEnB, (activeK % 4 == 0) ? 1 : 0);
      checkOutput("pclkDiv4", pclkB, (activeK % 4 >= 2) ? 1 : 0);
    end
  endtask

  task automatic applyStimulus(input int n, input bit s);
    stdby = s;
    repeat (n) stepEdge();
  endtask

  task automatic resetDut();
    sbRec_t rec;
    @(negedge clki);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstPclk", pclk, 0);
    checkOutput("rstPclkEn", pclkEn, 0);
    checkOutput("rstLock", lock, 0);
    checkOutput("rstPclk4", pclk4, 0);
    checkOutput("rstPclkEn4", pclkEn4, 0);
    checkOutput("rstLock4", lock4, 0);
    checkOutput("rstPclkB", pclkB, 0);
    checkOutput("rstPclkEnB", pclkEnB, 0);
    checkOutput("rstLockB", lockB, 0);
    checkOutput("queueEmptyAtReset", sbQ.size(), 0);
    sbQ.delete();
    edgeNo     = 0;
    activeK    = 0;
    strobeCnt  = 0;
    intervalOn = 1'b0;
    directedOn = 1'b0;
    stdby      = 1'b0;
    repeat (2) @(posedge clki);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rec.edgeNo  = handEdges[i];
      rec.lockExp = 1'b0;
      sbQ.push_back(rec);
    end
    handUntil  = 43;
    directedOn = 1'b1;
  endtask

  initial begin
    $display("[TB] pixel_clock_gen bench start");
    resetDut();
    intervalOn = 1'b1;
    applyStimulus(53200, 1'b0);
    @(negedge clki);
    #1;
    checkOutput("strobeCount53200", strobeTotal, 10070, 1);
    checkOutput("lockAfterRun", lock, 1);
    checkOutput("lock4AfterRun", lock4, 1);
    intervalOn = 1'b0;
    directedOn = 1'b0;

    stdby = 1'b0;
    while (!strobeAt(activeK + 1)) stepEdge();
    applyStimulus(1, 1'b1);
    checkOutput("lockFirstStdby", lock, 0);
    checkOutput("lock4FirstStdby", lock4, 0);
    checkOutput("pclkEnFirstStdby", pclkEn, 0);
    checkOutput("accFirstStdby", longint'(dut.acc_q), accModel(activeK));
    checkOutput("pclkFirstStdby", pclk, longint'(accModel(activeK) >> 31));
    applyStimulus(19, 1'b1);
    checkOutput("lockEndStdby", lock, 0);
    checkOutput("accEndStdby", longint'(dut.acc_q), accModel(activeK));
    checkOutput("pclkEndStdby", pclk, longint'(accModel(activeK) >> 31));
    applyStimulus(5600, 1'b0);
    checkOutput("lockRelock", lock, 1);

    resetDut();
    applyStimulus(60, 1'b0);
    @(negedge clki);
    #1;
    checkOutput("queueDrained", sbQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
